// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_arb_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Increment modulo n, so non-power-of-two ranges never reach unused codes.
  function automatic int wrap_inc(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             valid,
  output logic [ID_W-1:0]  index
);

  logic [N_REQ-1:0] rotated;
  logic [ID_W-1:0]  offset;
  logic [ID_W:0]    sum;

  // rotated[j] corresponds to requester (rr_ptr + j) mod N_REQ
  assign rotated = N_REQ'({req, req} >> rr_ptr);

  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        valid  = 1'b1;
        offset = ID_W'(j);
      end
    end
  end

  assign sum   = {1'b0, rr_ptr} + {1'b0, offset};
  assign index = (sum >= (ID_W + 1)'(N_REQ)) ? ID_W'(sum - (ID_W + 1)'(N_REQ))
                                             : sum[ID_W-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART serializer between N_REQ character sources,
// with start/busy sequencing and a start-timeout error pulse.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int WORD_W        = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                      clock,
  input  logic                      n_reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WORD_W-1:0]   req_data,
  output logic [N_REQ-1:0]          grant,
  output logic                      tx_start,
  output logic [WORD_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [$clog2(N_REQ)-1:0]  active_id,
  output logic                      arb_busy,
  output logic                      start_err,
  output tx_arb_state_t             state_dbg
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int TMR_W = id_width(START_TIMEOUT);

  // Handshake: req[i] is a level held (with stable data) until grant[i]
  // pulses; that pulse means the character was captured. The requester may
  // present its next character from the cycle after the grant onwards.

  tx_arb_state_t    state_q, state_d;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_valid;
  logic [TMR_W-1:0] timer;
  logic             load;
  logic             release_ptr;
  logic             timeout;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    release_ptr = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        // A still-busy serializer (e.g. stale frame after reset) blocks arbitration.
        if (!tx_busy && pick_valid) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
          timeout     = 1'b1;
          release_ptr = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          release_ptr = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      grant     <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      active_id <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
    end else begin
      grant    <= load ? (N_REQ'(1) << pick_idx) : '0;
      tx_start <= load;
      if (load) begin
        tx_data   <= req_data[pick_idx*WORD_W +: WORD_W];
        active_id <= pick_idx;
      end
      if (state_q == ISSUE) begin
        timer <= '0;
      end else if (state_q == WAIT_BUSY && !tx_busy) begin
        timer <= timer + 1'b1;
      end
      // Pointer moves past the served requester whether the frame completed or timed out.
      if (release_ptr) begin
        rr_ptr <= ID_W'(wrap_inc(int'(active_id), N_REQ));
      end
    end
  end

  assign start_err = timeout;
  assign arb_busy  = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic                 clock = 1'b0;
  logic                 n_reset = 1'b0;
  logic [N-1:0]         req = '0;
  logic [N*W-1:0]       req_data = '0;
  logic [N-1:0]         grant;
  logic                 tx_start;
  logic [W-1:0]         tx_data;
  logic                 tx_busy = 1'b0;
  logic [1:0]           active_id;
  logic                 arb_busy;
  logic                 start_err;
  uart_pkg::tx_arb_state_t state_dbg;

  uart_tx_arbiter #(.N_REQ(N), .WORD_W(W), .START_TIMEOUT(TO)) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .req       (req),
    .req_data  (req_data),
    .grant     (grant),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .active_id (active_id),
    .arb_busy  (arb_busy),
    .start_err (start_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           m_phase;   // 0 free, 1 start cycle, 2 awaiting busy, 3 awaiting end of frame
  int           m_ptr;
  int           m_id;
  int           m_issue;   // cycle in which tx_start is expected
  logic [N-1:0] e_grant;
  logic         e_start;
  logic [W-1:0] e_data;
  int           wait_cnt[N];

  // ---------------- serializer model / requester state ----------------
  int ser_cnt;
  int frame_len = 10;
  bit ser_dead;
  bit forced_busy;
  bit prev_busy;
  bit rand_mode;
  int fall_cyc;
  int start_cyc;
  int err_cyc;
  int rq_rem[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d actual timeout required event", name, cyc);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ptr   = 0;
    m_id    = 0;
    m_issue = 0;
    e_grant = '0;
    e_start = 1'b0;
    e_data  = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic exp_err;
    #1;
    exp_err = (m_phase == 2) && !tx_busy && (cyc - m_issue == TO);
    chk("grant",     32'(grant),     32'(e_grant));
    chk("tx_start",  32'(tx_start),  32'(e_start));
    chk("tx_data",   32'(tx_data),   32'(e_data));
    chk("active_id", 32'(active_id), 32'(m_id));
    chk("arb_busy",  32'(arb_busy),  32'(m_phase != 0));
    chk("start_err", 32'(start_err), 32'(exp_err));
    if (tx_start === 1'b1) begin
      start_cyc = cyc;
      if (exp_q.size() == 0) chk("sb_depth", 32'(exp_q.size()), 32'd1);
      else chk("sb_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (start_err === 1'b1) err_cyc = cyc;
  endtask

  // Advances the model across the coming clock edge using this cycle's inputs.
  task automatic model_step();
    e_grant = '0;
    e_start = 1'b0;
    for (int i = 0; i < N; i++) if (!req[i]) wait_cnt[i] = 0;
    case (m_phase)
      0: begin
        if (!tx_busy && req != '0) begin
          int pick = -1;
          for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (pick < 0 && req[i]) pick = i;
          end
          e_grant = N'(1) << pick;
          e_start = 1'b1;
          e_data  = req_data[pick*W +: W];
          m_id    = pick;
          m_issue = cyc + 1;
          m_phase = 1;
          exp_q.push_back(e_data);
          for (int i = 0; i < N; i++) begin
            if (i != pick && req[i]) begin
              wait_cnt[i]++;
              chk("fair_wait", 32'(wait_cnt[i] <= N - 1), 32'd1);
            end
          end
          wait_cnt[pick] = 0;
        end
      end
      1: m_phase = 2;
      2: begin
        if (tx_busy) m_phase = 3;
        else if (cyc - m_issue == TO) begin
          m_phase = 0;
          m_ptr   = (m_id + 1) % N;
        end
      end
      default: begin
        if (!tx_busy) begin
          m_phase = 0;
          m_ptr   = (m_id + 1) % N;
        end
      end
    endcase
  endtask

  task automatic ser_update();
    bit dead;
    if (ser_cnt > 0) begin
      tx_busy = 1'b1;
      ser_cnt--;
    end else begin
      tx_busy = forced_busy;
    end
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
    if (tx_start === 1'b1) begin
      dead = ser_dead;
      if (rand_mode) begin
        frame_len = $urandom_range(1, 12);
        dead      = ($urandom_range(0, 15) == 0);
      end
      if (!dead) ser_cnt = frame_len;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic raise(input int i, input logic [W-1:0] d, input int rem);
    req_data[i*W +: W] = d;
    rq_rem[i] = rem;
    req[i] = 1'b1;
  endtask

  task automatic drv_update();
    for (int i = 0; i < N; i++) begin
      if (grant[i] === 1'b1) begin
        if (rq_rem[i] > 0) rq_rem[i]--;
        if (rq_rem[i] == 0) req[i] = 1'b0;
        else if (rand_mode) req_data[i*W +: W] = W'($urandom);
      end else if (rand_mode) begin
        if (!req[i] && $urandom_range(0, 7) == 0) raise(i, W'($urandom), $urandom_range(1, 3));
        else if (req[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
          rq_rem[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    check_outputs();
    model_step();
    @(posedge clock);
    #1;
    cyc++;
    ser_update();
    drv_update();
    #1;
  endtask

  task automatic reset_dut(input bit busy);
    n_reset     = 1'b0;
    req         = '0;
    req_data    = '0;
    for (int i = 0; i < N; i++) rq_rem[i] = 0;
    forced_busy = busy;
    tx_busy     = busy;
    prev_busy   = busy;
    ser_cnt     = 0;
    ser_dead    = 1'b0;
    rand_mode   = 1'b0;
    frame_len   = 10;
    model_reset();
    @(posedge clock);
    #1;
    chk("rst_grant",    32'(grant),    32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_arb_busy", 32'(arb_busy), 32'd0);
    @(posedge clock);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic wait_grant(output int id, output logic [W-1:0] d, output int gc);
    id = -1;
    d  = '0;
    gc = cyc;
    for (int n = 0; n < 80 && id < 0; n++) begin
      tick();
      if (|grant === 1'b1) begin
        for (int i = 0; i < N; i++) if (grant[i]) id = i;
        d  = tx_data;
        gc = cyc;
      end
    end
    if (id < 0) fail_timeout("grant_wait");
  endtask

  task automatic drain(output int idle_cyc);
    for (int n = 0; n < 80 && arb_busy !== 1'b0; n++) tick();
    if (arb_busy !== 1'b0) fail_timeout("drain");
    idle_cyc = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int id, gc, rc, ic, cnt;
    logic [W-1:0] d;
    int exp_ids[6];
    logic [W-1:0] exp_dat[6];

    // Single request, 10-cycle frame
    reset_dut(1'b0);
    raise(0, 8'h41, 1);
    rc = cyc;
    wait_grant(id, d, gc);
    chk("single_id",      32'(id),      32'd0);
    chk("single_grant",   32'(grant),   32'b0001);
    chk("single_start",   32'(tx_start), 32'd1);
    chk("single_latency", 32'(gc - rc), 32'd1);
    chk("single_data",    32'(d),       32'h41);
    drain(ic);
    chk("single_idle_after_fall", 32'(ic - fall_cyc), 32'd1);
    chk("single_frame_span",      32'(ic - gc),       32'd12);

    // Fairness with all four requesting continuously
    reset_dut(1'b0);
    for (int i = 0; i < N; i++) raise(i, 8'hA0 + W'(i), 100);
    exp_ids = '{0, 1, 2, 3, 0, 1};
    exp_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};
    for (int k = 0; k < 6; k++) begin
      wait_grant(id, d, gc);
      chk("fair_order", 32'(id), 32'(exp_ids[k]));
      chk("fair_data",  32'(d),  32'(exp_dat[k]));
    end
    req = '0;
    for (int i = 0; i < N; i++) rq_rem[i] = 0;
    drain(ic);

    // Rotation skip: after serving 0, requester 3 comes before 0
    reset_dut(1'b0);
    raise(0, 8'h11, 1);
    wait_grant(id, d, gc);
    drain(ic);
    raise(0, 8'h22, 1);
    raise(3, 8'h33, 1);
    wait_grant(id, d, gc);
    chk("skip_first",  32'(id), 32'd3);
    chk("skip_data",   32'(d),  32'h33);
    wait_grant(id, d, gc);
    chk("skip_second", 32'(id), 32'd0);
    drain(ic);

    // Start timeout: serializer ignores the start pulse
    reset_dut(1'b0);
    ser_dead = 1'b1;
    raise(1, 8'h55, 1);
    raise(3, 8'h77, 1);
    wait_grant(id, d, gc);
    chk("to_first", 32'(id), 32'd1);
    err_cyc = -1;
    for (int n = 0; n < 40 && err_cyc < 0; n++) begin
      tick();
      if (start_err === 1'b1) err_cyc = cyc;
    end
    if (err_cyc < 0) fail_timeout("start_err_wait");
    else chk("to_delay", 32'(err_cyc - gc), 32'd16);
    ser_dead = 1'b0;
    wait_grant(id, d, gc);
    chk("to_next", 32'(id), 32'd3);
    chk("to_next_data", 32'(d), 32'h77);
    drain(ic);

    // Serializer busy at reset release
    reset_dut(1'b1);
    raise(2, 8'h99, 1);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (|grant === 1'b1 || tx_start === 1'b1) cnt++;
    end
    chk("busy_hold_no_grant", 32'(cnt), 32'd0);
    forced_busy = 1'b0;
    tx_busy     = 1'b0;
    prev_busy   = 1'b0;
    rc = cyc;
    wait_grant(id, d, gc);
    chk("busy_release_id",      32'(id),      32'd2);
    chk("busy_release_latency", 32'(gc - rc), 32'd1);
    drain(ic);

    // Asynchronous reset in the middle of a frame
    reset_dut(1'b0);
    raise(2, 8'h21, 1);
    wait_grant(id, d, gc);
    drain(ic);
    raise(3, 8'h5A, 1);
    wait_grant(id, d, gc);
    chk("mid_pre_id", 32'(id), 32'd3);
    for (int n = 0; n < 4; n++) tick();
    #1;
    n_reset = 1'b0;
    #1;
    chk("mid_grant",     32'(grant),     32'd0);
    chk("mid_tx_start",  32'(tx_start),  32'd0);
    chk("mid_tx_data",   32'(tx_data),   32'd0);
    chk("mid_active_id", 32'(active_id), 32'd0);
    chk("mid_arb_busy",  32'(arb_busy),  32'd0);
    chk("mid_start_err", 32'(start_err), 32'd0);
    chk("mid_state",     32'(state_dbg), 32'd0);
    reset_dut(1'b0);
    raise(0, 8'h10, 1);
    raise(3, 8'h13, 1);
    wait_grant(id, d, gc);
    chk("mid_restart_id", 32'(id), 32'd0);
    drain(ic);

    // Randomized traffic
    reset_dut(1'b0);
    rand_mode = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) rq_rem[i] = 0;
    drain(ic);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d actual running required finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit serializer (PISO with start/busy handshake) between N_REQ requesters, e.g. CPU TX peripheral, RX echo path and debug monitor.
- Round-robin arbitration; accepts one character per grant.
- Sequences the serializer: start pulse, then wait for busy to rise, then wait for busy to fall.
- Flags a serializer that fails to respond to a start pulse.

Parameters:
N_REQ, 4, number of requesters (2..8)
WORD_W, 8, character width
START_TIMEOUT, 16, cycles allowed in WAIT_BUSY for tx_busy to rise after tx_start

Ports:
clock  input  1  system clock; single clock domain, serializer runs on the same clock
n_reset  input  1  asynchronous, active-low reset
req  input  N_REQ  per-requester request; level, held until granted
req_data  input  N_REQ*WORD_W  flattened characters; slice i = req_data[i*WORD_W +: WORD_W]; stable while req[i]=1
grant  output  N_REQ  one-hot, one-cycle pulse: character of requester i captured
tx_start  output  1  one-cycle pulse to serializer
tx_data  output  WORD_W  registered character for serializer; stable from tx_start until return to IDLE
tx_busy  input  1  serializer busy, high while shifting
active_id  output  $clog2(N_REQ)  index of the current/last granted requester
arb_busy  output  1  high in every state except IDLE
start_err  output  1  one-cycle pulse on START_TIMEOUT expiry

Behaviour:
- Reset, asynchronous: all outputs 0; state IDLE; rr_ptr=0; timer=0. Reset mid-character drops tx_start immediately; the partial character is lost.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE, arbitrates only when tx_busy=0 and |req:
  - Pick the first set req at index rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ.
  - Register tx_data <= slice, active_id <= index, grant[index] <= 1 (visible next cycle), then go to ISSUE.
  - If tx_busy=1 (e.g. a stale transfer after reset), stay in IDLE.
- ISSUE: tx_start=1 for exactly this cycle; timer <= 0; go to WAIT_BUSY. grant is high during this cycle only.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise timer++.
  - When timer==START_TIMEOUT-1 with tx_busy still 0: start_err pulse, rr_ptr <= active_id+1 (mod N_REQ), go to IDLE. The character is dropped and not retried.
- WAIT_DONE: on tx_busy=0, rr_ptr <= active_id+1 (mod N_REQ) and go to IDLE.
- Latency: req sampled in IDLE to grant/tx_start is 1 cycle; both registered and coincident.
- Minimum spacing between grants is the serializer frame plus 3 cycles.
- Requester protocol:
  - A requester with more data holds req and, in the cycle after its grant, presents the next character.
  - Lowering req before grant withdraws the request with no side effects.
  - req is ignored outside IDLE.
- Fairness: a requester holding req waits at most N_REQ-1 other characters.
- Non-power-of-two N_REQ: rr_ptr wraps from N_REQ-1 to 0 and never takes unused encodings.
- Simultaneous tx_busy fall and new req: IDLE is entered first; the grant comes one cycle later.

Decomposition:
- Package uart_pkg gains:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} tx_arb_state_t
  - localparam ID_W = $clog2(N_REQ) as a function helper
- Sub-module rr_pick (combinational): inputs req and rr_ptr; outputs valid and index via rotate, priority encode, unrotate. Reused by later shared-resource blocks.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'h41, serializer model busy for 10 cycles. Expect grant=4'b0001 and tx_start 1 cycle later, tx_data=8'h41, arb_busy low 1 cycle after busy falls.
- Fairness: req=4'b1111 held continuously, distinct data 8'hA0..8'hA3. Expect grant order 0,1,2,3,0,1 and tx_data sequence A0,A1,A2,A3,A0,A1.
- Rotation skip: rr_ptr=1 after serving 0, then req=4'b1001. Expect requester 3 granted before 0.
- Start timeout: serializer model never raises busy, req=4'b0010. Expect start_err pulse exactly 16 cycles after tx_start; return to IDLE; next pending requester served.
- Busy at reset release: tx_busy=1 with req=4'b0100. Expect no grant and no tx_start until tx_busy falls, then grant[2].
- Reset mid-operation: assert n_reset in WAIT_DONE. Expect all outputs 0 asynchronously; after release, arbitration restarts from requester 0.
